// File: rtl/nlc_pkg.sv
// Shared types and elaboration helpers for the non-linear corrector front end.
// Holds the framer state encoding, default LFSR tap masks and the counter-width rule.
package nlc_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Maximal-length Fibonacci masks, MSB-first tap convention.
  function automatic logic [31:0] default_taps(input int m);
    case (m)
      3:       return 32'b110;
      4:       return 32'b1100;
      5:       return 32'b10100;
      default: return 32'b110;
    endcase
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/nlc_lfsr.sv
// Seeded Fibonacci LFSR with step enable; an all-zero seed is forced to 1
// so the register can never lock up in the zero state.
module nlc_lfsr #(
  parameter int               WIDTH = 3,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(3'b110),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  output logic [WIDTH-1:0] state
);

  localparam logic [WIDTH-1:0] INIT = (SEED == '0) ? WIDTH'(1) : SEED;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
    end else if (step) begin
      state <= {state[WIDTH-2:0], ^(state & TAPS)};
    end
  end

endmodule

// File: rtl/nlc_entropy_framer.sv
// Frames serial raw-entropy bits into words for the non-linear corrector and
// holds each word plus its LFSR snapshot until the corrector reports done.
module nlc_entropy_framer
  import nlc_pkg::*;
#(
  parameter int                 M_WIDTH     = 3,
  parameter int                 INPUT_WIDTH = 10,
  parameter logic [M_WIDTH-1:0] LFSR_TAPS   = M_WIDTH'(default_taps(M_WIDTH)),
  parameter logic [M_WIDTH-1:0] LFSR_SEED   = M_WIDTH'(1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   raw_bit,
  input  logic                   raw_valid,
  output logic [INPUT_WIDTH-1:0] in_word,
  output logic [M_WIDTH-1:0]     lfsr_out,
  output logic                   start,
  input  logic                   done,
  output logic                   busy,
  output logic                   overflow
);

  localparam int             CW   = cnt_width(INPUT_WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(INPUT_WIDTH - 1);

  state_t        state, state_next;
  logic [CW-1:0] bit_cnt;
  logic          accept;
  logic          drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // A bit arriving with done in HOLD opens the next word instead of being lost.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    drop       = 1'b0;
    case (state)
      FILL: begin
        if (raw_valid) begin
          accept = 1'b1;
          if (bit_cnt == LAST) begin
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (done) begin
          state_next = FILL;
          accept     = raw_valid;
        end else begin
          drop = raw_valid;
        end
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_word  <= '0;
      bit_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        in_word <= {in_word[INPUT_WIDTH-2:0], raw_bit};
        bit_cnt <= (bit_cnt == LAST) ? '0 : bit_cnt + CW'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  assign start = (state == HOLD);
  assign busy  = (state == HOLD);

  nlc_lfsr #(
    .WIDTH (M_WIDTH),
    .TAPS  (LFSR_TAPS),
    .SEED  (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .step  (accept),
    .state (lfsr_out)
  );

endmodule

// File: tb/tb_nlc_entropy_framer.sv
// Self-checking bench for nlc_entropy_framer: directed scenarios plus random
// traffic compared against a word/step-count reference model.
module tb_nlc_entropy_framer;

  localparam int MW = 3;
  localparam int IW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          raw_bit = 1'b0;
  logic          raw_valid = 1'b0;
  logic          done = 1'b0;
  logic [IW-1:0] in_word, in_word_z;
  logic [MW-1:0] lfsr_out, lfsr_out_z;
  logic          start, start_z, busy, busy_z, overflow, overflow_z;

  always #5 clk = ~clk;

  nlc_entropy_framer #(.M_WIDTH(MW), .INPUT_WIDTH(IW), .LFSR_TAPS(3'b110), .LFSR_SEED(3'd1)) dut (
    .clk(clk), .rst(rst), .raw_bit(raw_bit), .raw_valid(raw_valid),
    .in_word(in_word), .lfsr_out(lfsr_out), .start(start), .done(done),
    .busy(busy), .overflow(overflow)
  );

  nlc_entropy_framer #(.M_WIDTH(MW), .INPUT_WIDTH(IW), .LFSR_TAPS(3'b110), .LFSR_SEED(3'd0)) dut_z (
    .clk(clk), .rst(rst), .raw_bit(raw_bit), .raw_valid(raw_valid),
    .in_word(in_word_z), .lfsr_out(lfsr_out_z), .start(start_z), .done(done),
    .busy(busy_z), .overflow(overflow_z)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: word = last IW accepted bits, LFSR = position in the
  // 7-long x^3+x^2+1 sequence starting at 001.
  logic [MW-1:0] seq [7] = '{3'b001, 3'b010, 3'b101, 3'b011, 3'b111, 3'b110, 3'b100};
  int   hist[$];
  int   acc_total = 0;
  bit   m_hold    = 0;
  bit   m_ovf     = 0;

  function automatic logic [IW-1:0] exp_word();
    logic [IW-1:0] w = '0;
    int n = hist.size();
    for (int i = 0; i < IW; i++) begin
      if (n - 1 - i >= 0) w[i] = hist[n-1-i][0];
    end
    return w;
  endfunction

  function automatic logic [MW-1:0] exp_lfsr();
    return seq[acc_total % 7];
  endfunction

  task automatic model_accept(input logic b);
    hist.push_back(int'(b));
    if (hist.size() > IW) void'(hist.pop_front());
    acc_total++;
    if (acc_total % IW == 0) m_hold = 1;
  endtask

  task automatic cyc(input logic rv, input logic rb, input logic dn, input logic rs);
    raw_valid = rv; raw_bit = rb; done = dn; rst = rs;
    @(posedge clk);
    #1;
    if (rs) begin
      hist.delete(); acc_total = 0; m_hold = 0; m_ovf = 0;
    end else if (!m_hold) begin
      if (rv) model_accept(rb);
    end else if (dn) begin
      m_hold = 0;
      if (rv) model_accept(rb);
    end else if (rv) begin
      m_ovf = 1;
    end
    raw_valid = 1'b0; raw_bit = 1'b0; done = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    cyc(0, 0, 0, 1);
    total++; if (in_word !== '0)   begin bad++; $display("FAIL reset_in_word got=%h exp=0", in_word); end
    total++; if (lfsr_out !== 3'b001) begin bad++; $display("FAIL reset_lfsr got=%b exp=001", lfsr_out); end
    total++; if ({start, busy, overflow} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {start, busy, overflow}); end
    total++; if (lfsr_out_z !== 3'b001) begin bad++; $display("FAIL seed0_lfsr got=%b exp=001", lfsr_out_z); end
  endtask

  task automatic test_directed_word();
    logic [IW-1:0] pat = 10'b1011001110;
    cyc(0, 0, 0, 1);
    for (int i = 0; i < IW; i++) begin
      cyc(1, pat[IW-1-i], 0, 0);
      if (i == IW - 2) begin
        total++; if (start !== 1'b0) begin bad++; $display("FAIL early_start got=%b exp=0", start); end
      end
    end
    total++; if (in_word !== 10'h2CE) begin bad++; $display("FAIL word_value got=%h exp=2ce", in_word); end
    total++; if (lfsr_out !== 3'b011) begin bad++; $display("FAIL word_lfsr got=%b exp=011", lfsr_out); end
    total++; if ({start, busy} !== 2'b11) begin bad++; $display("FAIL word_start got=%b exp=11", {start, busy}); end
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0);
      total++;
      if (in_word !== 10'h2CE || lfsr_out !== 3'b011 || start !== 1'b1) begin
        bad++; $display("FAIL hold_stable got=%h/%b/%b exp=2ce/011/1", in_word, lfsr_out, start);
      end
    end
  endtask

  task automatic test_overflow();
    cyc(1, 1, 0, 0);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    total++; if (in_word !== 10'h2CE || lfsr_out !== 3'b011) begin bad++; $display("FAIL ovf_frozen got=%h/%b exp=2ce/011", in_word, lfsr_out); end
    cyc(0, 0, 0, 0);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    cyc(0, 0, 1, 0);
    total++; if ({start, busy, overflow} !== 3'b001) begin bad++; $display("FAIL ovf_after_done got=%b exp=001", {start, busy, overflow}); end
    cyc(0, 0, 1, 0);
    total++; if (start !== 1'b0 || overflow !== 1'b1) begin bad++; $display("FAIL done_in_fill got=%b%b exp=01", start, overflow); end
  endtask

  task automatic test_done_with_bit();
    cyc(0, 0, 0, 1);
    for (int i = 0; i < IW; i++) cyc(1, 1'($urandom_range(0, 1)), 0, 0);
    cyc(1, 1, 1, 0);
    total++; if (start !== 1'b0 || overflow !== 1'b0) begin bad++; $display("FAIL dwb_flags got=%b%b exp=00", start, overflow); end
    total++; if (in_word[0] !== 1'b1 || in_word !== exp_word()) begin bad++; $display("FAIL dwb_word got=%h exp=%h", in_word, exp_word()); end
    total++; if (lfsr_out !== 3'b111) begin bad++; $display("FAIL dwb_lfsr got=%b exp=111", lfsr_out); end
    for (int i = 0; i < IW - 2; i++) cyc(1, 0, 0, 0);
    total++; if (start !== 1'b0) begin bad++; $display("FAIL dwb_count9 got=%b exp=0", start); end
    cyc(1, 0, 0, 0);
    total++; if (start !== 1'b1) begin bad++; $display("FAIL dwb_count10 got=%b exp=1", start); end
  endtask

  task automatic test_gapped();
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 7; i++) begin
      cyc(1, 1'($urandom_range(0, 1)), 0, 0);
      cyc(0, 1, 0, 0);
      cyc(0, 0, 0, 0);
      total++; if (lfsr_out !== seq[(i + 1) % 7]) begin bad++; $display("FAIL gap_lfsr step=%0d got=%b exp=%b", i + 1, lfsr_out, seq[(i + 1) % 7]); end
    end
    total++; if (lfsr_out !== 3'b001) begin bad++; $display("FAIL gap_period got=%b exp=001", lfsr_out); end
  endtask

  task automatic test_reset_mid();
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 6; i++) cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 1);
    total++; if (in_word !== '0 || lfsr_out !== 3'b001 || {start, busy, overflow} !== 3'b000) begin
      bad++; $display("FAIL rst_mid got=%h/%b/%b exp=000/001/000", in_word, lfsr_out, {start, busy, overflow});
    end
    for (int i = 0; i < IW - 1; i++) cyc(1, 0, 0, 0);
    total++; if (start !== 1'b0) begin bad++; $display("FAIL rst_mid_9 got=%b exp=0", start); end
    cyc(1, 0, 0, 0);
    total++; if (start !== 1'b1) begin bad++; $display("FAIL rst_mid_10 got=%b exp=1", start); end
    cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 1);
    total++; if (overflow !== 1'b0 || start !== 1'b0) begin bad++; $display("FAIL rst_hold got=%b%b exp=00", overflow, start); end
  endtask

  task automatic test_back_to_back();
    int highs = 0;
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 5 * IW; i++) begin
      cyc(1, 1'($urandom_range(0, 1)), 1, 0);
      if (start) highs++;
      total++; if (in_word !== exp_word() || start !== m_hold) begin bad++; $display("FAIL b2b_cycle i=%0d got=%h/%b exp=%h/%b", i, in_word, start, exp_word(), m_hold); end
    end
    total++; if (highs !== 5) begin bad++; $display("FAIL b2b_pulses got=%0d exp=5", highs); end
  endtask

  task automatic test_random();
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 149) == 0));
      total++;
      if (in_word !== exp_word() || lfsr_out !== exp_lfsr() || start !== m_hold ||
          busy !== m_hold || overflow !== m_ovf || lfsr_out_z !== exp_lfsr()) begin
        bad++;
        $display("FAIL rand_cycle i=%0d got=%h/%b/%b%b%b/%b exp=%h/%b/%b%b%b",
                 i, in_word, lfsr_out, start, busy, overflow, lfsr_out_z,
                 exp_word(), exp_lfsr(), m_hold, m_hold, m_ovf);
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_directed_word();
    test_overflow();
    test_done_with_bit();
    test_gapped();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
